// File: rtl/mult_seq_n.sv
// mult_seq_n: sequential shift-add multiplier, one multiplier bit retired per clock.
// Supports unsigned and two's complement operands. Signed operands are converted to
// magnitudes on start, multiplied unsigned, and the product is negated in a final FIX
// cycle when the operand signs differ. Latency is fixed at WIDTH+1 cycles after the
// sampling edge.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        request a multiply (accepted only when idle or done)
//   signed_op    1 = two's complement operands/product, 0 = unsigned
//   multiplicand operand A, sampled with start
//   multiplier   operand B, sampled with start
//   busy         high while the operation is in progress (RUN, FIX)
//   ready        high while the product is valid (DONE)
//   product      2*WIDTH-bit result register
//   count        iterations completed in the current operation

module mult_seq_n #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               ready,
    output logic [2*WIDTH-1:0] product,
    output logic [CW-1:0]      count
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [CW-1:0]        count_q, count_d;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       sum;
    logic [CW-1:0]        count_inc;

    // Operand magnitudes; the magnitude of the most negative value still fits unsigned.
    always_comb begin
        mag_a = (signed_op && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
        mag_b = (signed_op && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
    end

    // Partial-product add keeps the carry so the shift can bring it into the top bit.
    always_comb begin
        if (product_q[0]) begin
            sum = {1'b0, product_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        end else begin
            sum = {1'b0, product_q[2*WIDTH-1:WIDTH]};
        end
        count_inc = count_q + CW'(1);
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        neg_d     = neg_q;
        product_d = product_q;
        count_d   = count_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    mcand_d   = mag_a;
                    product_d = {{WIDTH{1'b0}}, mag_b};
                    neg_d     = signed_op & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    count_d   = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                product_d = {sum, product_q[WIDTH-1:1]};
                count_d   = count_inc;
                if (count_inc == CW'(WIDTH)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                if (neg_q) begin
                    product_d = -product_q;
                end
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            count_q   <= count_d;
        end
    end

    assign busy    = (state_q == StRun) || (state_q == StFix);
    assign ready   = (state_q == StDone);
    assign product = product_q;
    assign count   = count_q;

endmodule

// File: doc/mult_seq_n.md
# mult_seq_n

Parametrised sequential shift-add multiplier with integrated control and datapath, sitting in the ALU beside the adder/logic units and driven by the multiply opcode decode. It generalises the fixed 16-bit multiplier to any operand width and adds a signed (two's complement) mode. It provides a start/busy/ready handshake and a result that stays stable until the next operation. One multiplier bit is retired per clock, so latency is fixed and deterministic.

## Interface
- WIDTH, 16, operand width in bits; legal range 2..32; product is 2*WIDTH bits.
- CW, $clog2(WIDTH+1), iteration counter width; derived, not to be overridden.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset; clears all state immediately on assertion.
- start  in  1  request a multiply; sampled on rising clk only in IDLE or DONE.
- signed_op  in  1  1 = operands and product are two's complement; 0 = unsigned; sampled with start.
- multiplicand  in  WIDTH  operand A; sampled with start.
- multiplier  in  WIDTH  operand B; sampled with start.
- busy  out  1  high in RUN and FIX.
- ready  out  1  high in DONE; product valid while high.
- product  out  2*WIDTH  result register; meaningful only while ready=1.
- count  out  CW  iterations completed in the current operation; debug/observability.

## Operation
- States: IDLE, RUN, FIX, DONE. Reset state IDLE.
- Reset values: busy=0, ready=0, product=0, count=0, internal multiplicand register=0, negate flag=0.
- IDLE/DONE, start=1:
  - latch mcand = |A| and load product = {WIDTH zeros, |B|}, where |x| is the two's complement magnitude if signed_op=1 and x[WIDTH-1]=1, else x;
  - latch neg = signed_op & (A[WIDTH-1] ^ B[WIDTH-1]); count=0; go to RUN.
- IDLE/DONE, start=0: hold state and all registers.
- RUN, each cycle:
  - if product[0]=1, form sum = product[2W-1:W] + mcand as WIDTH+1 bits (carry kept); else sum = {0, product[2W-1:W]};
  - product <= {sum, product[W-1:1]} (logical right shift by one with carry in at the top);
  - count += 1; when count reaches WIDTH (after this update) go to FIX.
- FIX: if neg=1, product <= two's complement negate of product (2W bits); else hold. Go to DONE.
- DONE: ready=1; product, count=WIDTH held until a new start.
- start while busy=1 is ignored; operand/signed_op changes during RUN/FIX have no effect.
- Magnitude of -2^(W-1) is 2^(W-1) and fits in WIDTH unsigned bits; (-2^(W-1))*(-2^(W-1)) = 2^(2W-2) fits in the 2W signed product. No overflow flag is needed.
- Unsigned mode: product is the exact 2W-bit unsigned result; signed mode: exact 2W-bit two's complement result.
- Zero operands take the full latency; there is no early exit.

## Timing
- Start sampled at edge E0 -> busy=1 from E0 to E(WIDTH+1); ready=1 after edge E(WIDTH+1). Total latency is WIDTH+1 cycles after the sampling edge.
- Back-to-back: start held high in DONE is sampled at the first DONE edge. ready is high for exactly one cycle, then the next operation begins. Start held continuously gives one result every WIDTH+2 cycles.
- ready and busy are never high together; both are low only in IDLE.
- reset_n asserted mid-RUN/FIX/DONE: all outputs return to reset values asynchronously. The first start after release is accepted normally.
- All outputs are registered or pure decodes of the state register; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=16, unsigned, A=0xFFFF, B=0xFFFF -> ready 17 cycles after start edge, product=0xFFFE0001, busy high for exactly 17 cycles.
- WIDTH=16, signed, A=0x8000, B=0x8000 -> product=0x40000000; A=0xFFFD (-3), B=0x0007 -> product=0xFFFFFFEB (-21).
- WIDTH=8, signed_op=0 vs 1 with A=0x80, B=0x02 -> unsigned product=0x0100; signed product=0xFF00; ready after 9 cycles.
- Start pulsed repeatedly during RUN with new operands -> ignored; result equals the first operands; start held high in DONE -> next op begins, ready low for 17 cycles.
- reset_n dropped at count=5 mid-RUN -> busy/ready/product/count=0 immediately; new start after release -> correct result with full latency.
- Randomised 1000 ops at WIDTH=2, 13, 32 in both modes against a reference model -> all products match and latency is always WIDTH+1.
